// File: rtl/wf_pkg.sv
// Shared constants, FSM state type and one-hot helper for the wavefront fetch scheduler.
package wf_pkg;
   localparam int NUM_WF  = 40;
   localparam int WFID_W  = 6;
   localparam int PC_W    = 32;
   localparam int INSTR_W = 32;

   localparam logic [WFID_W-1:0] LAST_WFID = 6'd39;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } fetch_state_e;

   function automatic logic [NUM_WF-1:0] wf_onehot(input logic [WFID_W-1:0] id);
      logic [NUM_WF-1:0] v;
      v = {NUM_WF{1'b0}};
      if (id <= LAST_WFID) begin
         v[id] = 1'b1;
      end else begin
         v = {NUM_WF{1'b0}};
      end
      return v;
   endfunction
endpackage

// File: rtl/wf_fetch_sched_rr.sv
// Combinational round-robin picker over 40 wavefronts, searching upward from last grant + 1.
module rr_arb_40
   import wf_pkg::*;
(
   input  logic [NUM_WF-1:0] req_i,
   input  logic [WFID_W-1:0] last_i,
   output logic [WFID_W-1:0] gnt_o,
   output logic              any_o
);

   logic [WFID_W:0] idx;

   // First requester found after the last grant wins; the search wraps at 40.
   always_comb begin
      gnt_o = {WFID_W{1'b0}};
      any_o = 1'b0;
      idx   = {(WFID_W+1){1'b0}};
      for (int k = 1; k <= NUM_WF; k++) begin
         idx = {1'b0, last_i} + 7'(k);
         if (idx >= 7'(NUM_WF)) begin
            idx = idx - 7'(NUM_WF);
         end else begin
            idx = idx;
         end
         if (!any_o && req_i[idx[WFID_W-1:0]]) begin
            gnt_o = idx[WFID_W-1:0];
            any_o = 1'b1;
         end else begin
            any_o = any_o;
         end
      end
   end

endmodule

// File: rtl/wf_fetch_sched.sv
// Wavefront instruction-fetch scheduler: round-robin fetch requests, per-wavefront PC/pending/discard.
// Optional build macro WF_FETCH_PERF_EN adds saturating accepted-fetch and stall counters.
module wf_fetch_sched
   import wf_pkg::*;
#(
   parameter logic [PC_W-1:0] FETCH_PC_INCR = 32'd4
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_WF-1:0]         wf_valid,
   input  logic [NUM_WF-1:0]         stop_fetch,
   input  logic [NUM_WF-1:0]         q_reset,
   input  logic                      pc_load,
   input  logic [WFID_W-1:0]         pc_load_wfid,
   input  logic [PC_W-1:0]           pc_load_value,
   output logic                      fetch_req_valid,
   input  logic                      fetch_req_ready,
   output logic [WFID_W-1:0]         fetch_req_wfid,
   output logic [PC_W-1:0]           fetch_req_pc,
   input  logic                      fetch_rsp_valid,
   input  logic [WFID_W-1:0]         fetch_rsp_wfid,
   input  logic [INSTR_W-1:0]        fetch_rsp_instr,
   output logic [NUM_WF-1:0]         q_vtail_incr,
   output logic [NUM_WF-1:0]         q_wr,
`ifdef WF_FETCH_PERF_EN
   output logic [31:0]               perf_fetch_cnt,
   output logic [31:0]               perf_stall_cnt,
`endif
   output logic [INSTR_W+PC_W-1:0]   instr_pc_out
);

   fetch_state_e              state_q, state_d;
   logic [WFID_W-1:0]         req_wfid_q, req_wfid_d;
   logic [PC_W-1:0]           req_pc_q, req_pc_d;
   logic [WFID_W-1:0]         last_q, last_d;
   logic                      flush_q, flush_d;
   logic [PC_W-1:0]           pc_q [NUM_WF];
   logic [PC_W-1:0]           pc_d [NUM_WF];
   logic [PC_W-1:0]           fetch_pc_q [NUM_WF];
   logic [PC_W-1:0]           fetch_pc_d [NUM_WF];
   logic [NUM_WF-1:0]         pending_q, pending_d;
   logic [NUM_WF-1:0]         discard_q, discard_d;
   logic [NUM_WF-1:0]         q_wr_q, q_wr_d;
   logic [INSTR_W+PC_W-1:0]   instr_pc_q, instr_pc_d;

   logic [NUM_WF-1:0]         eligible;
   logic [WFID_W-1:0]         rr_gnt;
   logic                      rr_any;
   logic                      accept;
   logic                      rsp_hit;

   assign eligible = wf_valid & ~stop_fetch & ~pending_q & ~discard_q;
   assign accept   = (state_q == ST_REQ) && fetch_req_ready && !rst;
   assign rsp_hit  = fetch_rsp_valid && (fetch_rsp_wfid <= LAST_WFID);

   rr_arb_40 u_rr (
      .req_i  (eligible),
      .last_i (last_q),
      .gnt_o  (rr_gnt),
      .any_o  (rr_any)
   );

   // Next-state logic: FSM, per-wavefront bookkeeping and response delivery.
   always_comb begin
      state_d    = state_q;
      req_wfid_d = req_wfid_q;
      req_pc_d   = req_pc_q;
      last_d     = last_q;
      flush_d    = flush_q;
      pc_d       = pc_q;
      fetch_pc_d = fetch_pc_q;
      q_wr_d     = {NUM_WF{1'b0}};
      instr_pc_d = instr_pc_q;
      // A flush turns an outstanding fetch into one whose response must be dropped.
      pending_d  = pending_q & ~q_reset;
      discard_d  = discard_q | (pending_q & q_reset);

      case (state_q)
         ST_IDLE: begin
            if (rr_any) begin
               state_d    = ST_REQ;
               req_wfid_d = rr_gnt;
               req_pc_d   = pc_q[rr_gnt];
               last_d     = rr_gnt;
               flush_d    = q_reset[rr_gnt];
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (fetch_req_ready) begin
               state_d = ST_IDLE;
            end else begin
               flush_d = flush_q | q_reset[req_wfid_q];
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A response racing a flush is simply consumed without a queue write.
      if (rsp_hit) begin
         if (pending_q[fetch_rsp_wfid]) begin
            pending_d[fetch_rsp_wfid] = 1'b0;
            discard_d[fetch_rsp_wfid] = 1'b0;
            if (!q_reset[fetch_rsp_wfid]) begin
               q_wr_d     = wf_onehot(fetch_rsp_wfid);
               instr_pc_d = {fetch_rsp_instr, fetch_pc_q[fetch_rsp_wfid]};
            end else begin
               q_wr_d = {NUM_WF{1'b0}};
            end
         end else if (discard_q[fetch_rsp_wfid]) begin
            discard_d[fetch_rsp_wfid] = 1'b0;
         end else begin
            q_wr_d = {NUM_WF{1'b0}};
         end
      end else begin
         q_wr_d = {NUM_WF{1'b0}};
      end

      if (accept) begin
         if (flush_q || q_reset[req_wfid_q]) begin
            discard_d[req_wfid_q] = 1'b1;
         end else begin
            pending_d[req_wfid_q] = 1'b1;
         end
         fetch_pc_d[req_wfid_q] = req_pc_q;
         pc_d[req_wfid_q]       = pc_q[req_wfid_q] + FETCH_PC_INCR;
      end else begin
         flush_d = flush_d;
      end

      // Applied after the increment so an explicit load always wins.
      if (pc_load && (pc_load_wfid <= LAST_WFID)) begin
         pc_d[pc_load_wfid] = pc_load_value;
      end else begin
         pc_d = pc_d;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         req_wfid_q <= {WFID_W{1'b0}};
         req_pc_q   <= {PC_W{1'b0}};
         last_q     <= LAST_WFID;
         flush_q    <= 1'b0;
         pending_q  <= {NUM_WF{1'b0}};
         discard_q  <= {NUM_WF{1'b0}};
         q_wr_q     <= {NUM_WF{1'b0}};
         instr_pc_q <= {(INSTR_W+PC_W){1'b0}};
         for (int i = 0; i < NUM_WF; i++) begin
            pc_q[i]       <= {PC_W{1'b0}};
            fetch_pc_q[i] <= {PC_W{1'b0}};
         end
      end else begin
         state_q    <= state_d;
         req_wfid_q <= req_wfid_d;
         req_pc_q   <= req_pc_d;
         last_q     <= last_d;
         flush_q    <= flush_d;
         pending_q  <= pending_d;
         discard_q  <= discard_d;
         q_wr_q     <= q_wr_d;
         instr_pc_q <= instr_pc_d;
         pc_q       <= pc_d;
         fetch_pc_q <= fetch_pc_d;
      end
   end

   assign fetch_req_valid = (state_q == ST_REQ);
   assign fetch_req_wfid  = req_wfid_q;
   assign fetch_req_pc    = req_pc_q;
   assign q_vtail_incr    = accept ? wf_onehot(req_wfid_q) : {NUM_WF{1'b0}};
   assign q_wr            = q_wr_q;
   assign instr_pc_out    = instr_pc_q;

`ifdef WF_FETCH_PERF_EN
   logic [31:0] fetch_cnt_q;
   logic [31:0] stall_cnt_q;

   // Saturating performance counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt_q <= 32'd0;
         stall_cnt_q <= 32'd0;
      end else begin
         if (accept && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
         end else begin
            fetch_cnt_q <= fetch_cnt_q;
         end
         if ((state_q == ST_REQ) && !fetch_req_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end else begin
            stall_cnt_q <= stall_cnt_q;
         end
      end
   end

   assign perf_fetch_cnt = fetch_cnt_q;
   assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule
